// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_pkg
//  Description : Shared types and helpers for the BCD countdown timer.
//                Holds the digit maxima, the FSM state encoding, the 36-bit
//                packed-BCD time type and the per-digit clamp helper.
//  Optional    : COUNTDOWN_AUTO_RELOAD_EN (used by countdown_timer only)
//  Revision    : 1.0  initial release
// ============================================================================
package countdown_pkg;

    localparam logic [3:0] DIG_MAX_9  = 4'd9;
    localparam logic [3:0] DIG_MAX_5  = 4'd5;
    localparam int         NUM_DIGITS = 9;

    // Packed BCD, LSB first: ms(3 digits), s(2), m(2), h(2)
    typedef logic [35:0] bcd_time_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Tens of seconds (digit 4) and tens of minutes (digit 6) stop at 5.
    function automatic logic [3:0] digit_max(input int idx);
        return ((idx == 4) || (idx == 6)) ? DIG_MAX_5 : DIG_MAX_9;
    endfunction

    // Saturate every digit to its own maximum so a bad preset can never
    // produce a non-BCD value on the display path.
    function automatic bcd_time_t clamp_bcd(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[i*4 +: 4] > digit_max(i)) begin
                r[i*4 +: 4] = digit_max(i);
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Counts enabled clock cycles modulo CLKS_PER_TICK and emits a
//                one-cycle tick on the cycle whose edge wraps the count to 0.
//                Synchronous clear; a paused (disabled) count is held.
//  Ports       : clk_i   - clock
//                resetn  - synchronous reset, active-low
//                i_en    - count enable
//                i_clr   - synchronous clear (wins over enable)
//                o_tick  - high in the cycle whose edge completes a period
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int CLKS_PER_TICK = 100000,
    parameter int TICK_W        = 17
) (
    input  logic clk_i,
    input  logic resetn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [TICK_W-1:0] c_last = TICK_W'(CLKS_PER_TICK - 1);

    logic [TICK_W-1:0] r_count;
    logic              w_at_last;

    assign w_at_last = (r_count == c_last);

    // The tick is combinational so the consumer acts on the same edge that
    // wraps the counter.
    assign o_tick = i_en && !i_clr && w_at_last;

    always_ff @(posedge clk_i) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : HH:MM:SS.mmm packed-BCD countdown timer. Loads a preset,
//                decrements once per CLKS_PER_TICK cycles while running and
//                flags expiry on reaching zero.
//  Optional    : COUNTDOWN_AUTO_RELOAD_EN - on reaching zero reload the last
//                loaded preset and keep running (periodic timer).
//  Ports       : clk_i      - clock
//                resetn     - synchronous reset, active-low
//                load_i     - load time_i (clamped) and go idle
//                time_i     - 36-bit packed-BCD preset
//                start_i    - start / resume
//                stop_i     - pause; acknowledge when expired
//                time_o     - remaining time, packed BCD
//                running_o  - high while counting
//                done_o     - one-cycle pulse on reaching zero
//                expired_o  - high while expired
//  Revision    : 1.0  initial release
// ============================================================================
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int CLKS_PER_TICK = 100000,
    parameter int TICK_W        = 17
) (
    input  logic        clk_i,
    input  logic        resetn,
    input  logic        load_i,
    input  logic [35:0] time_i,
    input  logic        start_i,
    input  logic        stop_i,
    output logic [35:0] time_o,
    output logic        running_o,
    output logic        done_o,
    output logic        expired_o
);

    state_t    r_state;
    bcd_time_t r_time;
    logic      r_running;
    logic      r_done;
    logic      r_expired;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    bcd_time_t r_reload;
`endif

    bcd_time_t w_time_load;
    bcd_time_t w_time_dec;
    logic      w_dec_zero;
    logic      w_tick;
    logic      w_presc_en;
    logic      w_presc_clr;
    logic      w_idle_start;

    // Ripple-borrow from the ms ones digit upwards; a 0 digit wraps to its
    // maximum and passes the borrow on.
    function automatic bcd_time_t bcd_decrement(input bcd_time_t t);
        bcd_time_t r;
        logic      borrow;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (t[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = digit_max(i);
                end else begin
                    r[i*4 +: 4] = t[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign w_time_load  = clamp_bcd(time_i);
    assign w_time_dec   = bcd_decrement(r_time);
    assign w_dec_zero   = (w_time_dec == '0);

    // stop_i outranks start_i, so a simultaneous stop blocks the start.
    assign w_idle_start = (r_state == IDLE) && start_i && !stop_i && (r_time != '0);

    // The prescaler keeps counting on a stop edge so a partial period is
    // preserved exactly across pause/resume.
    assign w_presc_en   = (r_state == RUN) && !load_i;
    assign w_presc_clr  = load_i || w_idle_start;

    tick_prescaler #(
        .CLKS_PER_TICK (CLKS_PER_TICK),
        .TICK_W        (TICK_W)
    ) u_prescaler (
        .clk_i  (clk_i),
        .resetn (resetn),
        .i_en   (w_presc_en),
        .i_clr  (w_presc_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk_i) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_time    <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            r_reload  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (load_i) begin
                r_time    <= w_time_load;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                r_reload  <= w_time_load;
`endif
                r_state   <= IDLE;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_idle_start) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end

                    RUN: begin
                        // A tick landing on the stop edge still counts, so
                        // no elapsed millisecond is ever lost.
                        if (w_tick) begin
                            if (w_dec_zero) begin
                                r_done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                                r_time <= r_reload;
`else
                                r_time <= '0;
`endif
                            end else begin
                                r_time <= w_time_dec;
                            end
                        end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (stop_i) begin
                            r_state   <= PAUSE;
                            r_running <= 1'b0;
                        end
`else
                        if (w_tick && w_dec_zero) begin
                            r_state   <= EXPIRED;
                            r_expired <= 1'b1;
                            r_running <= 1'b0;
                        end else if (stop_i) begin
                            r_state   <= PAUSE;
                            r_running <= 1'b0;
                        end
`endif
                    end

                    PAUSE: begin
                        if (!stop_i && start_i) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end

                    EXPIRED: begin
                        // start_i is deliberately ignored until acknowledged.
                        if (stop_i) begin
                            r_state   <= IDLE;
                            r_time    <= '0;
                            r_expired <= 1'b0;
                        end
                    end

                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign time_o    = r_time;
    assign running_o = r_running;
    assign done_o    = r_done;
    assign expired_o = r_expired;

endmodule

`default_nettype wire
